mat_data_store: RTL

MAT_DATA_STORE -- requirements
Module: MatDataStore

---
 rtl/mat_data_store_pkg.sv | 29 ++
 rtl/mat_data_store_fifo.sv | 70 +++++++
 rtl/mat_data_store.sv | 93 +++++++++
 3 files changed

// File: rtl/mat_data_store_pkg.sv
// mat_data_store_pkg -- shared matrix-unit types: data-memory ops and store-buffer FSM states.
// Rev 1.0
`default_nettype none

package mat_data_store_pkg;

  localparam int unsigned FLOAT_BITS = 32;

  typedef enum logic [1:0] {
    MAT_RD_NONE,
    MAT_RD_ROW,
    MAT_RD_COL
  } MatDataReadOp_t;

  typedef enum logic [1:0] {
    MAT_WR_NONE,
    MAT_WR_ROW,
    MAT_WR_COL
  } MatDataWriteOp_t;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    DONE
  } MatStoreState_t;

endpackage

`default_nettype wire

// File: rtl/mat_data_store_fifo.sv
// mat_data_store_fifo -- FIFO storage and pointer logic for buffered vector stores.
// Rev 1.0
`default_nettype none

module mat_data_store_fifo
  import mat_data_store_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                push_i,
  input  logic [ADDR_W-1:0]                   push_addr_i,
  input  logic [WIDTH-1:0][FLOAT_BITS-1:0]    push_data_i,
  input  logic                                pop_i,
  output logic [ADDR_W-1:0]                   head_addr_o,
  output logic [WIDTH-1:0][FLOAT_BITS-1:0]    head_data_o,
  output logic [CNT_W-1:0]                    count_o,
  output logic [CNT_W-1:0]                    count_next_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0]                addr_mem_q [DEPTH];
  logic [WIDTH-1:0][FLOAT_BITS-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]                 rd_ptr_q;
  logic [PTR_W-1:0]                 wr_ptr_q;
  logic [CNT_W-1:0]                 count_q;
  logic [CNT_W-1:0]                 count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so wrap is implicit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) begin
      addr_mem_q[wr_ptr_q] <= push_addr_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_addr_o  = addr_mem_q[rd_ptr_q];
  assign head_data_o  = data_mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

`default_nettype wire

// File: rtl/mat_data_store.sv
// mat_data_store -- buffers vector store requests and drains them in order to data memory, with flush.
// Rev 1.0
`default_nettype none

module mat_data_store
  import mat_data_store_pkg::*;
#(
  parameter int WIDTH              = 16,
  parameter int DATA_MEM_ADDR_SIZE = 32,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [DATA_MEM_ADDR_SIZE-1:0]          req_addr,
  input  logic [WIDTH-1:0][FLOAT_BITS-1:0]       req_data,
  input  logic                                   flush,
  output logic                                   flush_done,
  output logic                                   idle,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]        count,
  output logic                                   mem_write_en,
  output logic [DATA_MEM_ADDR_SIZE-1:0]          mem_write_addr,
  output logic [WIDTH-1:0][FLOAT_BITS-1:0]       mem_write_data,
  input  logic                                   mem_write_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  MatStoreState_t   state_q;
  logic             flush_done_q;
  logic [CNT_W-1:0] count_w;
  logic [CNT_W-1:0] count_next_w;
  logic             push_w;
  logic             pop_w;

  assign push_w = req_valid && req_ready;
  assign pop_w  = mem_write_en && mem_write_ready;

  mat_data_store_fifo #(
    .WIDTH  (WIDTH),
    .ADDR_W (DATA_MEM_ADDR_SIZE),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push_w),
    .push_addr_i  (req_addr),
    .push_data_i  (req_data),
    .pop_i        (pop_w),
    .head_addr_o  (mem_write_addr),
    .head_data_o  (mem_write_data),
    .count_o      (count_w),
    .count_next_o (count_next_w)
  );

  // FLUSH looks at next-cycle occupancy so flush_done lands one cycle after the final write.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (flush) state_q <= FLUSH;
        end
        FLUSH: begin
          if (count_next_w == '0) begin
            state_q      <= DONE;
            flush_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign req_ready    = (count_w < CNT_W'(FIFO_DEPTH)) && (state_q == RUN);
  assign mem_write_en = (count_w != '0);
  assign flush_done   = flush_done_q;
  assign idle         = (count_w == '0) && (state_q == RUN);
  assign count        = count_w;

endmodule

`default_nettype wire
